multi_decade_counter: RTL and testbench
=======================================

Name: multi_decade_counter

Overview:
Three-digit synchronous BCD counter (000–999) built from cascaded mod-10 decade stages: ones, tens, hundreds. Counts one step per clock while enabled. Flags the terminal count 999 so a higher stage or a controller can cascade or observe completion. Used as a general event/cycle counter with decimal-readable outputs.

Parameters:
None at top level; digit count fixed at 3.
Sub-module decade_counter: FINAL_VALUE, default 9, last value before wrap to 0.

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
enable  input  1  count enable; one increment per rising clk edge while high
done  output  1  terminal-count flag: high when enable=1 and count=999
ones  output  4  BCD units digit, 0–9
tens  output  4  BCD tens digit, 0–9
hundreds  output  4  BCD hundreds digit, 0–9

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (reset_n), applied immediately on falling reset_n regardless of clk.
- Reset: ones=0, tens=0, hundreds=0; done=0 (follows from count 000).
- Reset mid-count: digits clear to 000 immediately; counting resumes on the first rising edge after reset_n=1 with enable=1.
- enable=0 at a rising edge: all digits hold. enable is sampled synchronously; no latency beyond one edge.
- enable=1 at a rising edge: ones increments; ones 9 -> 0 and tens increments.
- tens 9 -> 0 and hundreds increments only when ones=9 and tens=9.
- Count 999 with enable=1: wraps to 000 at that edge.
- Stage carry: stage_done = stage_enable AND (digit == 9). Next stage enable = previous stage_done (ripple enable, not ripple clock; all flops on clk).
- done = enable AND ones==9 AND tens==9 AND hundreds==9. Combinational; high during the cycle whose edge causes the wrap; low otherwise, including at 999 with enable=0.
- Digits never leave 0–9. No illegal BCD codes reachable. Outputs are registered except done.
- enable X or Z is a bench error; the design need not define behaviour for it.

Decomposition:
- Package: none required. Optional localparams for BCD_MAX=4'd9 and DIGIT_W=4 in the top module.
- Sub-module decade_counter (clk, reset_n, enable, q[3:0], done), instantiated three times and chained enable -> done -> enable. Top module only wires the stages and ANDs the final done with enable.

Test Plan:
- Reset: reset_n=0 for 2 ns -> ones/tens/hundreds=0, done=0, asynchronously without a clock edge.
- Basic count: reset, then enable=1 for 115 rising edges -> hundreds=1, tens=1, ones=5; done never asserted.
- Carry: count to 009, one more edge -> 010; count to 099, one more edge -> 100.
- Hold: at 042 drop enable for 5 edges -> stays 042, done=0; re-enable -> 043 on next edge.
- Wrap: count to 999 with enable=1 -> done=1 during that cycle; next edge -> 000, done=0. At 999 with enable=0 -> done=0 and count holds.
- Mid-run reset: at 567 assert reset_n=0 between edges -> 000 immediately; release and count -> 001 on next enabled edge.

Source files
------------

// File: rtl/multi_decade_counter_pkg.sv
// Shared widths and limits for the three-digit BCD counter.
// Imported by the decade stage and the top.
package multi_decade_counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/multi_decade_counter_decade.sv
// One mod-(FINAL_VALUE+1) decade stage with an enable-qualified carry.
// Stages chain through ripple enables; all flops share clk.
module decade_counter
  import multi_decade_counter_pkg::*;
#(
  parameter digit_t FINAL_VALUE = BCD_MAX
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable,
  output digit_t q,
  output logic   done
);

  assign done = enable && (q == FINAL_VALUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      q <= done ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/multi_decade_counter.sv
// Three-digit BCD event counter (000-999) with a terminal-count flag.
// done is combinational and high only on the edge that wraps 999 to 000.
module multi_decade_counter
  import multi_decade_counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               done,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hundreds
);

  logic ones_done;
  logic tens_done;
  logic hund_done;

  decade_counter #(.FINAL_VALUE(BCD_MAX)) u_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .q       (ones),
    .done    (ones_done)
  );

  decade_counter #(.FINAL_VALUE(BCD_MAX)) u_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (ones_done),
    .q       (tens),
    .done    (tens_done)
  );

  decade_counter #(.FINAL_VALUE(BCD_MAX)) u_hund (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (tens_done),
    .q       (hundreds),
    .done    (hund_done)
  );

  assign done = enable && hund_done;

endmodule

// File: tb/tb_multi_decade_counter.sv
// Directed bench for multi_decade_counter.
// Expected counts are written as BCD hex literals.
module tb_multi_decade_counter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       done;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;

  int nvec;
  int nbad;
  logic seen;

  multi_decade_counter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .done     (done),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [11:0] obs,
                     input logic [11:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] cnt();
    return {hundreds, tens, ones};
  endfunction

  task automatic pulse_rst();
    reset_n = 1'b0;
    #1;
    chk("rst_async", cnt(), 12'h000);
    reset_n = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    seen = 1'b0;
    reset_n = 1'b0;
    enable = 1'b0;
    #2;
    chk("rst_cnt", cnt(), 12'h000);
    chk("rst_done", {11'd0, done}, 12'h000);
    #1;
    reset_n = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 115; i++) begin
      step(1);
      if (done) seen = 1'b1;
    end
    chk("basic_115", cnt(), 12'h115);
    chk("basic_nodone", {11'd0, seen}, 12'h000);

    pulse_rst();
    step(9);
    chk("carry_009", cnt(), 12'h009);
    step(1);
    chk("carry_010", cnt(), 12'h010);
    step(89);
    chk("carry_099", cnt(), 12'h099);
    chk("done_099", {11'd0, done}, 12'h000);
    step(1);
    chk("carry_100", cnt(), 12'h100);

    pulse_rst();
    step(42);
    chk("hold_042", cnt(), 12'h042);
    enable = 1'b0;
    step(5);
    chk("hold_keep", cnt(), 12'h042);
    chk("hold_done", {11'd0, done}, 12'h000);
    enable = 1'b1;
    step(1);
    chk("hold_043", cnt(), 12'h043);

    step(956);
    chk("wrap_999", cnt(), 12'h999);
    chk("wrap_done", {11'd0, done}, 12'h001);
    step(1);
    chk("wrap_000", cnt(), 12'h000);
    chk("wrap_done0", {11'd0, done}, 12'h000);

    step(999);
    chk("idle_999", cnt(), 12'h999);
    enable = 1'b0;
    #1;
    chk("idle_done", {11'd0, done}, 12'h000);
    step(3);
    chk("idle_hold", cnt(), 12'h999);

    enable = 1'b1;
    step(568);
    chk("mid_567", cnt(), 12'h567);
    reset_n = 1'b0;
    #1;
    chk("mid_rst", cnt(), 12'h000);
    chk("mid_done", {11'd0, done}, 12'h000);
    #1;
    reset_n = 1'b1;
    step(1);
    chk("mid_001", cnt(), 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
